// File: rtl/cci_mpf_shim_tx_buffer_to_fiu_if.sv
`default_nettype none
// ============================================================================
// Module      : cci_mpf_shim_tx_buffer_to_fiu_if
// Description : Request/almost-full bundle between the AFU-side shim stack,
//               the TX buffer and the FIU-side canonicalization stage.
// Revision    : 1.0 - initial release
// ============================================================================
interface cci_mpf_shim_tx_buffer_to_fiu_if #(
    parameter int C0_WIDTH = 128,
    parameter int C1_WIDTH = 640
);
    logic                afu_c0_valid;
    logic [C0_WIDTH-1:0] afu_c0_req;
    logic                afu_c1_valid;
    logic [C1_WIDTH-1:0] afu_c1_req;
    logic                afu_c0_almfull;
    logic                afu_c1_almfull;
    logic                fiu_c0_valid;
    logic [C0_WIDTH-1:0] fiu_c0_req;
    logic                fiu_c1_valid;
    logic [C1_WIDTH-1:0] fiu_c1_req;
    logic                fiu_c0_almfull;
    logic                fiu_c1_almfull;
    logic [1:0]          overflow_err;

    modport master (
        output afu_c0_valid, afu_c0_req, afu_c1_valid, afu_c1_req,
        output fiu_c0_almfull, fiu_c1_almfull,
        input  afu_c0_almfull, afu_c1_almfull,
        input  fiu_c0_valid, fiu_c0_req, fiu_c1_valid, fiu_c1_req,
        input  overflow_err
    );

    modport slave (
        input  afu_c0_valid, afu_c0_req, afu_c1_valid, afu_c1_req,
        input  fiu_c0_almfull, fiu_c1_almfull,
        output afu_c0_almfull, afu_c1_almfull,
        output fiu_c0_valid, fiu_c0_req, fiu_c1_valid, fiu_c1_req,
        output overflow_err
    );
endinterface
`default_nettype wire

// File: rtl/cci_mpf_shim_tx_buffer_to_fiu.sv
`default_nettype none
// ============================================================================
// Module      : cci_mpf_shim_tx_buffer_to_fiu
// Description : Per-channel elastic TX buffers absorbing the post-almfull slack
//               of the shim stack; forwards while downstream almfull is low.
// Revision    : 1.0 - initial release
// ============================================================================
module cci_mpf_shim_tx_buffer_to_fiu_chan #(
    parameter int DEPTH          = 16,
    parameter int ALM_FULL_SLACK = 4,
    parameter int WIDTH          = 128
) (
    input  wire logic             clk,
    input  wire logic             reset,
    input  wire logic             i_valid,
    input  wire logic [WIDTH-1:0] i_req,
    input  wire logic             i_dn_almfull,
    output logic                  o_almfull,
    output logic                  o_valid,
    output logic      [WIDTH-1:0] o_req,
    output logic                  o_overflow
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] c_FULL   = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] c_ALM_TH = CNT_W'(DEPTH - ALM_FULL_SLACK);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_almfull;
    logic             r_valid;
    logic [WIDTH-1:0] r_req;
    logic             r_overflow;

    logic             w_deq;
    logic             w_enq;
    logic [CNT_W-1:0] w_count_next;

    // A full buffer still accepts when the head leaves in the same cycle.
    assign w_deq = (r_count != '0) && !i_dn_almfull;
    assign w_enq = i_valid && ((r_count != c_FULL) || w_deq);

    always_comb begin
        w_count_next = r_count;
        if (w_enq && !w_deq) begin
            w_count_next = r_count + CNT_W'(1);
        end else if (!w_enq && w_deq) begin
            w_count_next = r_count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_mem[r_wr_ptr] <= i_req;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_almfull  <= 1'b1;
            r_valid    <= 1'b0;
            r_req      <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_count   <= w_count_next;
            r_almfull <= (w_count_next >= c_ALM_TH);
            r_valid   <= w_deq;
            if (w_enq) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_deq) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
                r_req    <= r_mem[r_rd_ptr];
            end
            if (i_valid && !w_enq) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign o_almfull  = r_almfull;
    assign o_valid    = r_valid;
    assign o_req      = r_req;
    assign o_overflow = r_overflow;
endmodule

module cci_mpf_shim_tx_buffer_to_fiu #(
    parameter int DEPTH          = 16,
    parameter int ALM_FULL_SLACK = 4,
    parameter int C0_WIDTH       = 128,
    parameter int C1_WIDTH       = 640
) (
    input  wire logic                  clk,
    input  wire logic                  reset,
    cci_mpf_shim_tx_buffer_to_fiu_if.slave bus
);
    logic w_ovf_c0;
    logic w_ovf_c1;

    cci_mpf_shim_tx_buffer_to_fiu_chan #(
        .DEPTH          (DEPTH),
        .ALM_FULL_SLACK (ALM_FULL_SLACK),
        .WIDTH          (C0_WIDTH)
    ) u_c0 (
        .clk          (clk),
        .reset        (reset),
        .i_valid      (bus.afu_c0_valid),
        .i_req        (bus.afu_c0_req),
        .i_dn_almfull (bus.fiu_c0_almfull),
        .o_almfull    (bus.afu_c0_almfull),
        .o_valid      (bus.fiu_c0_valid),
        .o_req        (bus.fiu_c0_req),
        .o_overflow   (w_ovf_c0)
    );

    cci_mpf_shim_tx_buffer_to_fiu_chan #(
        .DEPTH          (DEPTH),
        .ALM_FULL_SLACK (ALM_FULL_SLACK),
        .WIDTH          (C1_WIDTH)
    ) u_c1 (
        .clk          (clk),
        .reset        (reset),
        .i_valid      (bus.afu_c1_valid),
        .i_req        (bus.afu_c1_req),
        .i_dn_almfull (bus.fiu_c1_almfull),
        .o_almfull    (bus.afu_c1_almfull),
        .o_valid      (bus.fiu_c1_valid),
        .o_req        (bus.fiu_c1_req),
        .o_overflow   (w_ovf_c1)
    );

    assign bus.overflow_err = {w_ovf_c1, w_ovf_c0};
endmodule
`default_nettype wire
